// File: rtl/rv32i_decode_exec_pkg.sv
// Shared types for the RV32I decode/execute stage: opcodes, ALU operations,
// instruction formats and the PC-select / writeback-source encodings.
package rv32i_decode_exec_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_control_t;

    // NONE is zero so that a reset or NOP output reads as "no instruction".
    typedef enum logic [2:0] {
        IT_NONE = 3'd0,
        IT_R    = 3'd1,
        IT_I    = 3'd2,
        IT_S    = 3'd3,
        IT_B    = 3'd4,
        IT_U    = 3'd5,
        IT_J    = 3'd6
    } instruction_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_JAL    = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    localparam logic [2:0] RES_ALU   = 3'd0;
    localparam logic [2:0] RES_IMM   = 3'd1;
    localparam logic [2:0] RES_PCIMM = 3'd2;
    localparam logic [2:0] RES_PC4   = 3'd3;
    localparam logic [2:0] RES_MEM   = 3'd4;

    localparam logic [2:0] MEM_F3_WORD = 3'b010;

endpackage

// File: rtl/rv32i_alu_core.sv
// Purely combinational RV32I ALU: arithmetic/logic ops plus branch compares
// that return 1/0 in bit 0.
module rv32i_alu_core
    import rv32i_decode_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);

    logic [4:0] shamt;
    logic       eq;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b_i[4:0];
    assign eq    = (a_i == b_i);
    assign lt_s  = ($signed(a_i) < $signed(b_i));
    assign lt_u  = (a_i < b_i);

    always_comb begin
        y_o = '0;
        case (alu_control_t'(op_i))
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << shamt;
            ALU_SLT:  y_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: y_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_SRL:  y_o = a_i >> shamt;
            ALU_SRA:  y_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            ALU_BEQ:  y_o = {{(XLEN-1){1'b0}}, eq};
            ALU_BNE:  y_o = {{(XLEN-1){1'b0}}, ~eq};
            ALU_BLT:  y_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_BGE:  y_o = {{(XLEN-1){1'b0}}, ~lt_s};
            ALU_BLTU: y_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_BGEU: y_o = {{(XLEN-1){1'b0}}, ~lt_u};
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_exec.sv
// RV32I decode + immediate extend + ALU stage with a single registered output
// stage; data outputs hold their last value while no instruction is presented.
module rv32i_decode_exec
    import rv32i_decode_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] imm_ext,
    output logic [1:0]      pc_src,
    output logic [2:0]      result_src,
    output logic            alu_src,
    output logic            reg_wen,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [2:0]      mem_funct3,
    output logic [2:0]      instr_type
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [XLEN-1:0] imm_p0_d;
    alu_control_t    alu_op_p0_d;
    logic [1:0]      pc_src_p0_d;
    logic [2:0]      result_src_p0_d;
    logic            alu_src_p0_d;
    logic            reg_wen_p0_d;
    logic            mem_wen_p0_d;
    logic [2:0]      mem_funct3_p0_d;
    instruction_t    instr_type_p0_d;
    logic [XLEN-1:0] alu_in2_p0_d;
    logic [XLEN-1:0] alu_res_p0_d;
    logic [XLEN-1:0] mem_addr_p0_d;

    logic            vld_p1_q;
    logic [XLEN-1:0] alu_res_p1_q;
    logic [XLEN-1:0] imm_p1_q;
    logic [1:0]      pc_src_p1_q;
    logic [2:0]      result_src_p1_q;
    logic            alu_src_p1_q;
    logic            reg_wen_p1_q;
    logic            mem_wen_p1_q;
    logic [XLEN-1:0] mem_addr_p1_q;
    logic [2:0]      mem_funct3_p1_q;
    logic [2:0]      instr_type_p1_q;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Stage p0: decode control and pick the immediate for this opcode.
    always_comb begin
        imm_p0_d        = '0;
        alu_op_p0_d     = ALU_ADD;
        pc_src_p0_d     = PC_PLUS4;
        result_src_p0_d = RES_ALU;
        alu_src_p0_d    = 1'b0;
        reg_wen_p0_d    = 1'b0;
        mem_wen_p0_d    = 1'b0;
        mem_funct3_p0_d = MEM_F3_WORD;
        instr_type_p0_d = IT_NONE;

        case (opcode)
            OP_REG: begin
                instr_type_p0_d = IT_R;
                reg_wen_p0_d    = 1'b1;
                case (funct3)
                    3'b000:  alu_op_p0_d = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_p0_d = ALU_SLL;
                    3'b010:  alu_op_p0_d = ALU_SLT;
                    3'b011:  alu_op_p0_d = ALU_SLTU;
                    3'b100:  alu_op_p0_d = ALU_XOR;
                    3'b101:  alu_op_p0_d = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_p0_d = ALU_OR;
                    default: alu_op_p0_d = ALU_AND;
                endcase
            end
            OP_IMM: begin
                instr_type_p0_d = IT_I;
                imm_p0_d        = imm_i;
                alu_src_p0_d    = 1'b1;
                reg_wen_p0_d    = 1'b1;
                // No SUBI exists: instr[30] only matters for the right shift.
                case (funct3)
                    3'b000:  alu_op_p0_d = ALU_ADD;
                    3'b001:  alu_op_p0_d = ALU_SLL;
                    3'b010:  alu_op_p0_d = ALU_SLT;
                    3'b011:  alu_op_p0_d = ALU_SLTU;
                    3'b100:  alu_op_p0_d = ALU_XOR;
                    3'b101:  alu_op_p0_d = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_p0_d = ALU_OR;
                    default: alu_op_p0_d = ALU_AND;
                endcase
            end
            OP_LOAD: begin
                instr_type_p0_d = IT_I;
                imm_p0_d        = imm_i;
                alu_src_p0_d    = 1'b1;
                reg_wen_p0_d    = 1'b1;
                result_src_p0_d = RES_MEM;
                mem_funct3_p0_d = funct3;
            end
            OP_STORE: begin
                instr_type_p0_d = IT_S;
                imm_p0_d        = imm_s;
                alu_src_p0_d    = 1'b1;
                mem_wen_p0_d    = 1'b1;
                mem_funct3_p0_d = funct3;
            end
            OP_BRANCH: begin
                instr_type_p0_d = IT_B;
                imm_p0_d        = imm_b;
                pc_src_p0_d     = PC_BRANCH;
                case (funct3)
                    3'b001:  alu_op_p0_d = ALU_BNE;
                    3'b100:  alu_op_p0_d = ALU_BLT;
                    3'b101:  alu_op_p0_d = ALU_BGE;
                    3'b110:  alu_op_p0_d = ALU_BLTU;
                    3'b111:  alu_op_p0_d = ALU_BGEU;
                    default: alu_op_p0_d = ALU_BEQ;
                endcase
            end
            OP_JAL: begin
                instr_type_p0_d = IT_J;
                imm_p0_d        = imm_j;
                pc_src_p0_d     = PC_JAL;
                result_src_p0_d = RES_PC4;
                reg_wen_p0_d    = 1'b1;
            end
            OP_JALR: begin
                instr_type_p0_d = IT_I;
                imm_p0_d        = imm_i;
                alu_src_p0_d    = 1'b1;
                pc_src_p0_d     = PC_JALR;
                result_src_p0_d = RES_PC4;
                reg_wen_p0_d    = 1'b1;
            end
            OP_LUI: begin
                instr_type_p0_d = IT_U;
                imm_p0_d        = imm_u;
                result_src_p0_d = RES_IMM;
                reg_wen_p0_d    = 1'b1;
            end
            OP_AUIPC: begin
                instr_type_p0_d = IT_U;
                imm_p0_d        = imm_u;
                result_src_p0_d = RES_PCIMM;
                reg_wen_p0_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_in2_p0_d  = alu_src_p0_d ? imm_p0_d : rs2;
    assign mem_addr_p0_d = rs1 + imm_p0_d;

    rv32i_alu_core #(
        .XLEN (XLEN)
    ) u_alu (
        .op_i (alu_op_p0_d),
        .a_i  (rs1),
        .b_i  (alu_in2_p0_d),
        .y_o  (alu_res_p0_d)
    );

    // Stage p1: output register; data only advances on an accepted instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q        <= 1'b0;
            alu_res_p1_q    <= '0;
            imm_p1_q        <= '0;
            pc_src_p1_q     <= '0;
            result_src_p1_q <= '0;
            alu_src_p1_q    <= 1'b0;
            reg_wen_p1_q    <= 1'b0;
            mem_wen_p1_q    <= 1'b0;
            mem_addr_p1_q   <= '0;
            mem_funct3_p1_q <= '0;
            instr_type_p1_q <= '0;
        end else begin
            vld_p1_q <= in_valid;
            if (in_valid) begin
                alu_res_p1_q    <= alu_res_p0_d;
                imm_p1_q        <= imm_p0_d;
                pc_src_p1_q     <= pc_src_p0_d;
                result_src_p1_q <= result_src_p0_d;
                alu_src_p1_q    <= alu_src_p0_d;
                reg_wen_p1_q    <= reg_wen_p0_d;
                mem_wen_p1_q    <= mem_wen_p0_d;
                mem_addr_p1_q   <= mem_addr_p0_d;
                mem_funct3_p1_q <= mem_funct3_p0_d;
                instr_type_p1_q <= instr_type_p0_d;
            end
        end
    end

    assign out_valid  = vld_p1_q;
    assign alu_result = alu_res_p1_q;
    assign imm_ext    = imm_p1_q;
    assign pc_src     = pc_src_p1_q;
    assign result_src = result_src_p1_q;
    assign alu_src    = alu_src_p1_q;
    assign reg_wen    = reg_wen_p1_q;
    assign mem_wen    = mem_wen_p1_q;
    assign mem_addr   = mem_addr_p1_q;
    assign mem_funct3 = mem_funct3_p1_q;
    assign instr_type = instr_type_p1_q;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// Scoreboard bench for rv32i_decode_exec: directed and random instructions
// are modelled on issue and compared by an independent output monitor.
module tb_rv32i_decode_exec;
    import rv32i_decode_exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr, rs1, rs2;
    logic        out_valid;
    logic [31:0] alu_result, imm_ext, mem_addr;
    logic [1:0]  pc_src;
    logic [2:0]  result_src, mem_funct3, instr_type;
    logic        alu_src, reg_wen, mem_wen;

    always #5 clk = ~clk;

    rv32i_decode_exec #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .alu_result(alu_result), .imm_ext(imm_ext),
        .pc_src(pc_src), .result_src(result_src), .alu_src(alu_src),
        .reg_wen(reg_wen), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .instr_type(instr_type)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] addr;
        logic [1:0]  pc;
        logic [2:0]  res;
        logic [2:0]  f3;
        logic [2:0]  it;
        logic        asrc;
        logic        rw;
        logic        mw;
        logic        chk_alu;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return a == b;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [2:0]  f3 = ins[14:12];
        logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
        e = '{alu: 32'd0, imm: 32'd0, addr: 32'd0, pc: 2'd0, res: 3'd0, f3: 3'b010,
              it: IT_NONE, asrc: 1'b0, rw: 1'b0, mw: 1'b0, chk_alu: 1'b1};
        case (ins[6:0])
            7'b0110011: begin
                e.it = IT_R; e.rw = 1; e.alu = arith(f3, ins[30], a, b);
            end
            7'b0010011: begin
                e.it = IT_I; e.rw = 1; e.asrc = 1; e.imm = ii;
                e.alu = arith(f3, (f3 == 3'd5) && ins[30], a, ii);
            end
            7'b0000011: begin
                e.it = IT_I; e.rw = 1; e.asrc = 1; e.imm = ii; e.res = 3'd4;
                e.f3 = f3; e.alu = a + ii;
            end
            7'b0100011: begin
                e.it = IT_S; e.mw = 1; e.asrc = 1; e.f3 = f3;
                e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.alu = a + e.imm;
            end
            7'b1100011: begin
                e.it = IT_B; e.pc = 2'd3;
                e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                e.alu = taken(f3, a, b) ? 32'd1 : 32'd0;
            end
            7'b1101111: begin
                e.it = IT_J; e.pc = 2'd1; e.res = 3'd3; e.rw = 1; e.chk_alu = 0;
                e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin
                e.it = IT_I; e.pc = 2'd2; e.res = 3'd3; e.rw = 1; e.asrc = 1;
                e.imm = ii; e.alu = a + ii;
            end
            7'b0110111: begin
                e.it = IT_U; e.res = 3'd1; e.rw = 1; e.imm = {ins[31:12], 12'b0}; e.alu = a + b;
            end
            7'b0010111: begin
                e.it = IT_U; e.res = 3'd2; e.rw = 1; e.imm = {ins[31:12], 12'b0}; e.alu = a + b;
            end
            default: e.chk_alu = 0;
        endcase
        e.addr = a + e.imm;
        return e;
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        instr = ins; rs1 = a; rs2 = b; in_valid = 1'b1;
        q.push_back(model(ins, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pops on every valid output, otherwise checks the data holds.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.chk_alu) chk("alu_result", alu_result, e.alu);
                    chk("imm_ext", imm_ext, e.imm);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("pc_src", {30'd0, pc_src}, {30'd0, e.pc});
                    chk("result_src", {29'd0, result_src}, {29'd0, e.res});
                    chk("mem_funct3", {29'd0, mem_funct3}, {29'd0, e.f3});
                    chk("instr_type", {29'd0, instr_type}, {29'd0, e.it});
                    chk("alu_src", {31'd0, alu_src}, {31'd0, e.asrc});
                    chk("reg_wen", {31'd0, reg_wen}, {31'd0, e.rw});
                    chk("mem_wen", {31'd0, mem_wen}, {31'd0, e.mw});
                    if (e.chk_alu) last.alu = e.alu;
                    else last.alu = alu_result;
                    last.imm  = e.imm;
                    last.addr = e.addr;
                end
            end else begin
                chk("hold_alu_result", alu_result, last.alu);
                chk("hold_imm_ext", imm_ext, last.imm);
                chk("hold_mem_addr", mem_addr, last.addr);
            end
        end
    end

    localparam logic [6:0] KNOWN [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
        7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        bit          known;
        last = '{alu: 32'd0, imm: 32'd0, addr: 32'd0, pc: 2'd0, res: 3'd0, f3: 3'd0,
                 it: 3'd0, asrc: 1'b0, rw: 1'b0, mw: 1'b0, chk_alu: 1'b0};

        rst = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093; rs1 = 32'd5; rs2 = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_imm_ext", imm_ext, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ctrl", {16'd0, pc_src, result_src, mem_funct3, instr_type, alu_src, reg_wen, mem_wen}, 32'd0);

        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_rst_valid", {31'd0, out_valid}, 32'd0);
        mon_en = 1'b1;

        issue(32'hFFF00093, 32'h0, 32'h0);            // ADDI x1,x0,-1
        issue(32'h40208033, 32'd5, 32'd7);            // SUB
        issue(32'h4010D093, 32'h80000000, 32'h0);     // SRAI 1
        issue(32'hFE20CEE3, 32'hFFFFFFFF, 32'd1);     // BLT
        issue(32'hFE20EEE3, 32'hFFFFFFFF, 32'd1);     // BLTU
        issue(32'h00112223, 32'h100, 32'h0);          // SW
        @(posedge clk); #1;
        issue(32'h123450B7, 32'h0, 32'h0);            // LUI
        issue(32'h008000EF, 32'h0, 32'h0);            // JAL
        issue(32'h0000007F, 32'h1234, 32'h5678);      // unknown opcode
        issue(32'h0020F0B3, 32'hF0F0F0F0, 32'hFF00FF00); // AND
        issue(32'h0010D093, 32'h80000000, 32'h0);     // SRLI 1

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            case ($urandom_range(0, 9))
                9: begin
                    do begin
                        op = 7'($urandom_range(0, 127));
                        known = 1'b0;
                        for (int k = 0; k < 9; k++) if (op == KNOWN[k]) known = 1'b1;
                    end while (known);
                end
                default: op = KNOWN[$urandom_range(0, 8)];
            endcase
            issue({r[31:7], op}, $urandom(), ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
